// File: rtl/ps2_scan_capture.sv
// PS/2 device-to-host frame receiver. It keeps the two most recent make codes and
// filters out break and extended sequences and typematic repeats.
module ps2_scan_capture #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] num1,
    output logic [7:0] num2,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_s, dat_s;
    logic                   clk_filt;
    logic [FW-1:0]          filt_cnt;
    logic                   fall;

    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;

    logic       pend_ok, pend_err;
    logic [7:0] pend_byte;
    logic       brk, ext, held;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    assign fall = clk_filt & ~clk_s & (filt_cnt == FW'(FILTER_LEN - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign timeout_hit = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tcnt       <= '0;
            pend_ok    <= 1'b0;
            pend_err   <= 1'b0;
            pend_byte  <= '0;
        end else begin
            pend_ok  <= 1'b0;
            pend_err <= 1'b0;
            if (state == IDLE) begin
                tcnt <= '0;
                if (fall && !dat_s) begin
                    state  <= DATA;
                    bitcnt <= '0;
                end
            end else if (fall) begin
                tcnt <= '0;
                case (state)
                    DATA: begin
                        shreg  <= {dat_s, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= dat_s;
                        state      <= STOP;
                    end
                    default: begin
                        // Odd parity over data plus parity bit, and stop must be high.
                        if (dat_s && (^{shreg, parity_bit})) begin
                            pend_ok   <= 1'b1;
                            pend_byte <= shreg;
                        end else begin
                            pend_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            end else if (timeout_hit) begin
                state <= IDLE;
                tcnt  <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            num1       <= '0;
            num2       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            held       <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= pend_err | timeout_hit;
            if (pend_err) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end else if (pend_ok) begin
                if (pend_byte == 8'hE0) begin
                    ext <= 1'b1;
                end else if (pend_byte == 8'hF0) begin
                    brk <= 1'b1;
                end else if (brk) begin
                    if (pend_byte == num1) held <= 1'b0;
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else if (ext) begin
                    ext <= 1'b0;
                end else if (!(held && pend_byte == num1)) begin
                    num2       <= num1;
                    num1       <= pend_byte;
                    held       <= 1'b1;
                    code_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_capture.sv
// Scoreboard bench for ps2_scan_capture: the stimulus side queues expected events from a
// byte-level key model, and a monitor pops and compares them on every code_valid/frame_err.
module tb_ps2_scan_capture;

    localparam int HALF = 25;
    localparam int TMO  = 300;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] num1, num2;
    logic       code_valid, frame_err;

    ps2_scan_capture #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .num1      (num1),
        .num2      (num2),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       err;
        logic [7:0] n1;
        logic [7:0] n2;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Key-state model
    logic [7:0] m_num1 = 8'h00, m_num2 = 8'h00;
    bit         m_held = 0, m_brk = 0, m_ext = 0;

    // Monitor's view of the currently published codes
    logic [7:0] mon_n1 = 8'h00, mon_n2 = 8'h00;

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (m_brk) begin
            if (b == m_num1) m_held = 0;
            m_brk = 0;
            m_ext = 0;
        end else if (m_ext) m_ext = 0;
        else if (!(m_held && b == m_num1)) begin
            m_num2 = m_num1;
            m_num1 = b;
            m_held = 1;
            exp_q.push_back('{err: 1'b0, n1: m_num1, n2: m_num2});
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stop);
        ps2_dat = 1'b1;
        wait_clks(3 * HALF);
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        send_raw(b, ~^b, 1'b1);
    endtask

    task automatic send_bad(input logic [7:0] b, input logic par, input logic stop);
        exp_q.push_back('{err: 1'b1, n1: 8'h00, n2: 8'h00});
        m_brk = 0;
        m_ext = 0;
        send_raw(b, par, stop);
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, got, want);
        end
    endtask

    function automatic logic [7:0] pick();
        logic [7:0] keys [7];
        keys = '{8'h23, 8'h4B, 8'h1C, 8'h2D, 8'h75, 8'h16, 8'h1E};
        return keys[$urandom_range(0, 6)];
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            mon_n1 = 8'h00;
            mon_n2 = 8'h00;
        end else if (code_valid || frame_err) begin
            ev_t e;
            vectors++;
            if (code_valid && frame_err) begin
                miscompares++;
                $display("FAIL both_pulses: code_valid=1 frame_err=1 expected one at a time");
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: code_valid=%0b frame_err=%0b num1=%02h expected none",
                         code_valid, frame_err, num1);
            end else begin
                e = exp_q.pop_front();
                if (!e.err) begin
                    mon_n1 = e.n1;
                    mon_n2 = e.n2;
                end
                if (frame_err !== e.err || num1 !== mon_n1 || num2 !== mon_n2) begin
                    miscompares++;
                    $display("FAIL event: err=%0b num1=%02h num2=%02h expected err=%0b num1=%02h num2=%02h",
                             frame_err, num1, num2, e.err, mon_n1, mon_n2);
                end
            end
        end else begin
            vectors++;
            if (num1 !== mon_n1 || num2 !== mon_n2) begin
                miscompares++;
                $display("FAIL stable: num1=%02h num2=%02h expected %02h %02h",
                         num1, num2, mon_n1, mon_n2);
            end
        end
    end

    initial begin
        wait_clks(5);
        check8("reset_num1", num1, 8'h00);
        check8("reset_num2", num2, 8'h00);
        check8("reset_pulses", {6'd0, code_valid, frame_err}, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        wait_clks(20);

        // Captures, break and typematic handling
        send(8'h23);
        check8("t1_num1", num1, 8'h23);
        check8("t1_num2", num2, 8'h00);
        send(8'h4B);
        send(8'hF0);
        send(8'h4B);
        send(8'h4B);
        check8("t2_num1", num1, 8'h4B);
        check8("t2_num2", num2, 8'h4B);
        send(8'h23);
        send(8'h23);
        send(8'h23);
        send(8'hF0);
        send(8'h23);
        send(8'h23);

        // Framing errors
        send_bad(8'h23, 1'b1, 1'b1);
        send_bad(8'h23, 1'b0, 1'b0);
        send(8'h1C);
        check8("t4_num1", num1, 8'h1C);

        // Timeout after four data bits
        exp_q.push_back('{err: 1'b1, n1: 8'h00, n2: 8'h00});
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_dat = 1'b1;
        wait_clks(TMO + 100);
        send(8'h2D);
        send(8'hE0);
        send(8'h75);
        check8("t5_num1", num1, 8'h2D);

        // Reset mid-frame, then a short clock glitch
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        check8("t6_num1", num1, 8'h00);
        check8("t6_num2", num2, 8'h00);
        exp_q.delete();
        m_num1 = 8'h00; m_num2 = 8'h00; m_held = 0; m_brk = 0; m_ext = 0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_clks(5);
        @(negedge clock);
        reset = 1'b0;
        wait_clks(20);
        ps2_clk = 1'b0;
        wait_clks(2);
        ps2_clk = 1'b1;
        wait_clks(40);
        send(8'h23);
        check8("t6_after_num1", num1, 8'h23);

        // Randomized traffic
        for (int k = 0; k < 25; k++) begin
            logic [7:0] b;
            b = pick();
            case ($urandom_range(0, 9))
                0: begin
                    send(8'hF0);
                    send((m_num1 == 8'h00) ? b : m_num1);
                end
                1: begin
                    send(8'hE0);
                    send(b);
                end
                2: send_bad(b, ^b, 1'b1);
                3: send((m_num1 == 8'h00) ? b : m_num1);
                default: send(b);
            endcase
        end

        wait_clks(200);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d events outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
